carregador_programa: RTL

//  Writer side of the instruction-memory port that the processor reads. Receives a framed byte

---
 rtl/carregador_programa.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/carregador_programa.sv
// Program loader: takes a framed byte stream, writes the payload into instruction memory
// from address 0 and releases the processor only after a frame with a matching checksum.
module carregador_programa #(
  parameter logic [7:0] CABECALHO = 8'hA5,
  parameter int         TIMEOUT   = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  output logic       rx_ready,
  output logic       mem_we,
  output logic [7:0] mem_endereco,
  output logic [7:0] mem_dado,
  output logic       cpu_hold,
  output logic       done,
  output logic       erro
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    OCIOSO,
    TAMANHO,
    DADOS,
    CHECKSUM,
    CONCLUIDO
  } estado_t;

  estado_t    state_reg, state_next;
  logic [8:0] restante_reg, restante_next;
  logic [7:0] endereco_reg, endereco_next;
  logic [7:0] soma_reg, soma_next;
  logic [CW-1:0] ocioso_reg, ocioso_next;
  logic       rx_ready_reg, rx_ready_next;
  logic       mem_we_reg, mem_we_next;
  logic [7:0] mem_endereco_reg, mem_endereco_next;
  logic [7:0] mem_dado_reg, mem_dado_next;
  logic       cpu_hold_reg, cpu_hold_next;
  logic       done_reg, done_next;
  logic       erro_reg, erro_next;

  logic aceito;
  assign aceito = rx_valid && rx_ready_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg        <= OCIOSO;
      restante_reg     <= '0;
      endereco_reg     <= '0;
      soma_reg         <= '0;
      ocioso_reg       <= '0;
      rx_ready_reg     <= 1'b0;
      mem_we_reg       <= 1'b0;
      mem_endereco_reg <= '0;
      mem_dado_reg     <= '0;
      cpu_hold_reg     <= 1'b1;
      done_reg         <= 1'b0;
      erro_reg         <= 1'b0;
    end else begin
      state_reg        <= state_next;
      restante_reg     <= restante_next;
      endereco_reg     <= endereco_next;
      soma_reg         <= soma_next;
      ocioso_reg       <= ocioso_next;
      rx_ready_reg     <= rx_ready_next;
      mem_we_reg       <= mem_we_next;
      mem_endereco_reg <= mem_endereco_next;
      mem_dado_reg     <= mem_dado_next;
      cpu_hold_reg     <= cpu_hold_next;
      done_reg         <= done_next;
      erro_reg         <= erro_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    restante_next     = restante_reg;
    endereco_next     = endereco_reg;
    soma_next         = soma_reg;
    ocioso_next       = ocioso_reg;
    rx_ready_next     = 1'b1;
    mem_we_next       = 1'b0;
    mem_endereco_next = mem_endereco_reg;
    mem_dado_next     = mem_dado_reg;
    cpu_hold_next     = cpu_hold_reg;
    done_next         = done_reg;
    erro_next         = erro_reg;

    case (state_reg)
      OCIOSO, CONCLUIDO: begin
        if (aceito && rx_byte == CABECALHO) begin
          state_next    = TAMANHO;
          done_next     = 1'b0;
          erro_next     = 1'b0;
          cpu_hold_next = 1'b1;
          ocioso_next   = '0;
        end
      end

      TAMANHO, DADOS, CHECKSUM: begin
        if (!aceito) begin
          // Stalled sender: abandon the frame after TIMEOUT idle cycles.
          if (ocioso_reg == CW'(TIMEOUT - 1)) begin
            state_next    = OCIOSO;
            erro_next     = 1'b1;
            done_next     = 1'b0;
            cpu_hold_next = 1'b1;
            ocioso_next   = '0;
          end else begin
            ocioso_next = ocioso_reg + 1'b1;
          end
        end else begin
          ocioso_next = '0;
          case (state_reg)
            TAMANHO: begin
              restante_next = (rx_byte == 8'h00) ? 9'd256 : {1'b0, rx_byte};
              soma_next     = '0;
              endereco_next = '0;
              state_next    = DADOS;
            end
            DADOS: begin
              mem_we_next       = 1'b1;
              mem_endereco_next = endereco_reg;
              mem_dado_next     = rx_byte;
              endereco_next     = endereco_reg + 8'd1;
              soma_next         = soma_reg + rx_byte;
              restante_next     = restante_reg - 9'd1;
              if (restante_reg == 9'd1) begin
                state_next = CHECKSUM;
              end
            end
            default: begin
              if (rx_byte == soma_reg) begin
                done_next     = 1'b1;
                erro_next     = 1'b0;
                cpu_hold_next = 1'b0;
                state_next    = CONCLUIDO;
              end else begin
                done_next     = 1'b0;
                erro_next     = 1'b1;
                cpu_hold_next = 1'b1;
                state_next    = OCIOSO;
              end
            end
          endcase
        end
      end

      default: state_next = OCIOSO;
    endcase
  end

  assign rx_ready     = rx_ready_reg;
  assign mem_we       = mem_we_reg;
  assign mem_endereco = mem_endereco_reg;
  assign mem_dado     = mem_dado_reg;
  assign cpu_hold     = cpu_hold_reg;
  assign done         = done_reg;
  assign erro         = erro_reg;

endmodule
